hazard_unit: RTL

Pipeline hazard unit for the 5-stage ARM core. It sits beside the pipelined controller and drives the controller's `FlushE` along with the datapath's stall, flush and forwarding selects. It keeps its own shadow pipeline of register addresses and control bits (E, M, W), so it needs only Decode-stage inputs plus the Execute-stage condition and branch results. It also keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_unit_if.sv | 39 +++
 rtl/hazard_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Groups the hazard unit's pipeline-facing signals.
//   Decode inputs : RA1D, RA2D (sources), WA3D (destination),
//                   RegWriteD, MemtoRegD, PCSrcD (control before condition check)
//   Execute inputs: CondExE (condition passed), BranchTakenE (branch taken)
//   Outputs       : StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
//                   StallCount (saturating count of stalled decode cycles)
// The pipeline side uses modport master; the hazard unit uses modport slave.
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int CNTW = 16
);
    logic [3:0]      RA1D;
    logic [3:0]      RA2D;
    logic [3:0]      WA3D;
    logic            RegWriteD;
    logic            MemtoRegD;
    logic            PCSrcD;
    logic            CondExE;
    logic            BranchTakenE;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [CNTW-1:0] StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Hazard detection for the 5-stage ARM pipeline. Keeps a shadow copy of the
// register addresses and control bits for E, M and W so it only needs Decode
// inputs plus the Execute condition/branch results.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   hz    : hazard_unit_if.slave (Decode/Execute inputs, stall/flush/forward
//           outputs and the saturating stall-cycle counter)
// All hazard outputs are combinational from shadow state and Decode inputs.
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);
    // Execute-stage shadow
    logic [3:0]      ra1e_q;
    logic [3:0]      ra2e_q;
    logic [3:0]      wa3e_q;
    logic            regwritee_q;
    logic            memtorege_q;
    logic            pcsrce_q;
    // Memory-stage shadow
    logic [3:0]      wa3m_q;
    logic            regwritem_q;
    logic            pcsrcm_q;
    // Writeback-stage shadow
    logic [3:0]      wa3w_q;
    logic            regwritew_q;
    logic            pcsrcw_q;

    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;

    logic            ldr_stall;
    logic            pc_wr_pending;
    logic            flush_e;

    // M beats W so the youngest producer wins. R15 reads PC+8, never a
    // forwarded result.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa3m,
        input logic       rwm,
        input logic [3:0] wa3w,
        input logic       rww
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'd15) begin
            if (rwm && (ra == wa3m)) begin
                sel = 2'b10;
            end else if (rww && (ra == wa3w)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        ldr_stall     = ((hz.RA1D == wa3e_q) || (hz.RA2D == wa3e_q)) && memtorege_q && regwritee_q;
        pc_wr_pending = hz.PCSrcD | pcsrce_q | pcsrcm_q;
        flush_e       = ldr_stall | hz.BranchTakenE;

        stall_cnt_d = stall_cnt_q;
        if (ldr_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    assign hz.StallF     = ldr_stall | pc_wr_pending;
    assign hz.StallD     = ldr_stall;
    assign hz.FlushD     = pc_wr_pending | pcsrcw_q | hz.BranchTakenE;
    assign hz.FlushE     = flush_e;
    assign hz.ForwardAE  = fwd_sel(ra1e_q, wa3m_q, regwritem_q, wa3w_q, regwritew_q);
    assign hz.ForwardBE  = fwd_sel(ra2e_q, wa3m_q, regwritem_q, wa3w_q, regwritew_q);
    assign hz.StallCount = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1e_q      <= '0;
            ra2e_q      <= '0;
            wa3e_q      <= '0;
            regwritee_q <= 1'b0;
            memtorege_q <= 1'b0;
            pcsrce_q    <= 1'b0;
            wa3m_q      <= '0;
            regwritem_q <= 1'b0;
            pcsrcm_q    <= 1'b0;
            wa3w_q      <= '0;
            regwritew_q <= 1'b0;
            pcsrcw_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // The ID/EX clear wins over the load-use hold: a bubble goes in.
            if (flush_e) begin
                ra1e_q      <= '0;
                ra2e_q      <= '0;
                wa3e_q      <= '0;
                regwritee_q <= 1'b0;
                memtorege_q <= 1'b0;
                pcsrce_q    <= 1'b0;
            end else begin
                ra1e_q      <= hz.RA1D;
                ra2e_q      <= hz.RA2D;
                wa3e_q      <= hz.WA3D;
                regwritee_q <= hz.RegWriteD;
                memtorege_q <= hz.MemtoRegD;
                pcsrce_q    <= hz.PCSrcD;
            end
            // A failed condition kills the write and the PC update here.
            wa3m_q      <= wa3e_q;
            regwritem_q <= regwritee_q & hz.CondExE;
            pcsrcm_q    <= pcsrce_q & hz.CondExE;
            wa3w_q      <= wa3m_q;
            regwritew_q <= regwritem_q;
            pcsrcw_q    <= pcsrcm_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
